// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl shared types: FSM states, ls_size codes and byte-count helper.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_STORE
    } state_t;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    localparam int IF_BYTES = 4;

    localparam logic [31:0] ZERO_32 = '0;
    localparam logic [63:0] ZERO_64 = '0;

    // Doubleword falls back to word on 32-bit builds.
    function automatic logic [3:0] size_bytes(
        input logic [1:0] sz,
        input int         xlen
    );
        logic [3:0] n;
        case (sz)
            SZ_BYTE: n = 4'd1;
            SZ_HALF: n = 4'd2;
            SZ_WORD: n = 4'd4;
            default: n = (xlen == 64) ? 4'd8 : 4'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// mem_ctrl arbiter: IF vs LS grant with alternation on contention.
module mem_ctrl_arb
    import mem_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic if_req,
    input  logic ls_req,
    output logic gnt_if,
    output logic gnt_ls
);

    logic last_ls;

    always_comb begin
        gnt_ls = idle & ls_req & ~(if_req & last_ls);
        gnt_if = idle & if_req & ~gnt_ls;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_ls <= 1'b0;
        end else if (gnt_ls) begin
            last_ls <= 1'b1;
        end else if (gnt_if) begin
            last_ls <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller sharing one 8-bit port between IF and LS.
// Define MEM_CTRL_IBUF_EN for a one-entry fetch buffer.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int XLEN       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  flush,
    output logic [31:0]           if_inst,
    output logic                  if_done,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [1:0]            ls_size,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [XLEN-1:0]       ls_wdata,
    output logic [XLEN-1:0]       ls_rdata,
    output logic                  ls_done,
    input  logic [7:0]            ram_din,
    output logic [7:0]            ram_dout,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_wr
);

    localparam int NB = XLEN / 8;
    localparam int BW = $clog2(NB);

    state_t          state;
    logic [3:0]      cnt;
    logic [3:0]      len;
    logic [XLEN-1:0] sh_q;
    logic [XLEN-1:0] asm_w;
    logic [BW-1:0]   bidx;
    logic            if_ok;
    logic            hit;
    logic [31:0]     hit_inst;
    logic            gnt_if;
    logic            gnt_ls;
    logic            fetch_fin;

    assign if_ok     = if_req & ~flush;
    assign fetch_fin = (state == ST_FETCH) & ~flush & (cnt == len);

`ifdef MEM_CTRL_IBUF_EN
    logic [ADDR_WIDTH-1:0] ib_tag;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [31:0]           ib_inst;
    logic                  ib_valid;

    assign hit = (state == ST_IDLE) & if_ok & ib_valid
               & (ib_tag == if_addr);
    assign hit_inst = ib_inst;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ib_tag   <= '0;
            base_q   <= '0;
            ib_inst  <= ZERO_32;
            ib_valid <= 1'b0;
        end else begin
            if (gnt_if) begin
                base_q <= if_addr;
            end
            if (gnt_ls && ls_we) begin
                ib_valid <= 1'b0;
            end
            if (fetch_fin) begin
                ib_valid <= 1'b1;
                ib_tag   <= base_q;
                ib_inst  <= asm_w[31:0];
            end
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_inst = ZERO_32;
`endif

    // A buffer hit never competes for the RAM port.
    mem_ctrl_arb u_arb (
        .clk    (clk),
        .rst    (rst),
        .idle   (state == ST_IDLE),
        .if_req (if_ok & ~hit),
        .ls_req (ls_req),
        .gnt_if (gnt_if),
        .gnt_ls (gnt_ls)
    );

    // Byte lane for the incoming RAM byte; cnt leads the data by one edge.
    always_comb begin
        bidx  = BW'(cnt - 4'd1);
        asm_w = sh_q;
        asm_w[{bidx, 3'b000} +: 8] = ram_din;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            len      <= '0;
            sh_q     <= '0;
            if_inst  <= ZERO_32;
            ls_rdata <= ZERO_64[XLEN-1:0];
            ram_addr <= '0;
            ram_dout <= '0;
            if_done  <= 1'b0;
            ls_done  <= 1'b0;
            ram_wr   <= 1'b0;
        end else begin
            if_done <= 1'b0;
            ls_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    ram_wr <= 1'b0;
                    if (hit) begin
                        if_done <= 1'b1;
                        if_inst <= hit_inst;
                    end
                    if (gnt_ls) begin
                        len      <= size_bytes(ls_size, XLEN);
                        ram_addr <= ls_addr;
                        cnt      <= '0;
                        if (ls_we) begin
                            state    <= ST_STORE;
                            ram_wr   <= 1'b1;
                            ram_dout <= ls_wdata[7:0];
                            sh_q     <= ls_wdata >> 8;
                        end else begin
                            state <= ST_LOAD;
                            sh_q  <= '0;
                        end
                    end else if (gnt_if) begin
                        state    <= ST_FETCH;
                        len      <= 4'(IF_BYTES);
                        ram_addr <= if_addr;
                        cnt      <= '0;
                        sh_q     <= '0;
                    end
                end
                ST_FETCH, ST_LOAD: begin
                    if (state == ST_FETCH && flush) begin
                        state <= ST_IDLE;
                    end else begin
                        if (cnt != 4'd0) begin
                            sh_q <= asm_w;
                        end
                        if (cnt + 4'd1 < len) begin
                            ram_addr <= ram_addr + 1'b1;
                        end
                        if (cnt == len) begin
                            state <= ST_IDLE;
                            if (state == ST_FETCH) begin
                                if_done <= 1'b1;
                                if_inst <= asm_w[31:0];
                            end else begin
                                ls_done  <= 1'b1;
                                ls_rdata <= asm_w;
                            end
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                ST_STORE: begin
                    if (cnt + 4'd1 == len) begin
                        state   <= ST_IDLE;
                        ram_wr  <= 1'b0;
                        ls_done <= 1'b1;
                    end else begin
                        cnt      <= cnt + 4'd1;
                        ram_addr <= ram_addr + 1'b1;
                        ram_dout <= sh_q[7:0];
                        sh_q     <= sh_q >> 8;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
